// File: rtl/apu_mix_sched_if.sv
// apu_mix_sched_if: channel handshakes, mixer controls and serializer-side
// outputs of the per-frame APU mixer.
//
// Handshake: a sample on channel k transfers on a rising edge where
// ch_valid[k] and ch_ready[k] are both high. ch_ready is combinational,
// at most one bit is high in any cycle, and it only rises in channel k's
// gather slot. A source may hold ch_valid high across frames; it is consumed
// at most once per frame.
interface apu_mix_sched_if #(
    parameter int NUM_CH = 4
);
    logic [16*NUM_CH-1:0] ch_sample;
    logic [NUM_CH-1:0]    ch_valid;
    logic [NUM_CH-1:0]    ch_ready;
    logic [NUM_CH-1:0]    ch_enable;
    logic [2:0]           atten;
    logic                 underrun_clr;
    logic [NUM_CH-1:0]    underrun;
    logic                 frame_start;
    logic [15:0]          sample;

    // Voice channels / controller side
    modport master (
        output ch_sample, ch_valid, ch_enable, atten, underrun_clr,
        input  ch_ready, underrun, frame_start, sample
    );

    // Mixer side
    modport slave (
        input  ch_sample, ch_valid, ch_enable, atten, underrun_clr,
        output ch_ready, underrun, frame_start, sample
    );
endinterface

// File: rtl/apu_mix_sched.sv
// apu_mix_sched: once per audio frame, gathers one sample from each voice
// channel in index order, sums them, applies an arithmetic right shift,
// saturates to 16 bits and presents the result to the I2S serializer,
// held stable for a whole frame.
//
// Optional feature macro: APU_HOLD_LAST_EN. When defined, each channel keeps
// its last accepted sample and an underrun slot re-uses it instead of adding
// zero. Without it there is no per-channel storage.
//
// Frame timeline (frame_pos):
//   0                 WAIT -> GATHER, accumulator cleared
//   1 .. NUM_CH       GATHER, one channel slot per cycle
//   NUM_CH+1          SCALE, pending = sat16(acc >>> atten)
//   UPDATE_POS        sample <= pending at the end of this cycle
module apu_mix_sched #(
    parameter int NUM_CH     = 4,
    parameter int FRAME_LEN  = 32,
    parameter int UPDATE_POS = 8
) (
    input  logic           clock,
    input  logic           reset_l,
    apu_mix_sched_if.slave bus,
    output logic [1:0]     dbg_state_o
);
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int FP_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    // Sum of NUM_CH full-scale 16-bit samples plus sign: never overflows.
    localparam int ACC_W = 16 + $clog2(NUM_CH) + 1;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -(ACC_W'(32768));

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_GATHER = 2'd1,
        ST_SCALE  = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [FP_W-1:0]          frame_pos_q, frame_pos_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [15:0]              pending_q, pending_d;
    logic [15:0]              sample_q, sample_d;
    logic [NUM_CH-1:0]        underrun_q, underrun_d;

    logic [NUM_CH-1:0]        ready_c;
    logic [NUM_CH-1:0]        set_c;
    logic [15:0]              cur_sample;
    logic                     cur_en;
    logic                     cur_vld;
    logic [15:0]              fill_val;
    logic [15:0]              slot_val;
    logic signed [ACC_W-1:0]  shifted;

    // Current slot's channel inputs
    assign cur_sample = bus.ch_sample[16*int'(idx_q) +: 16];
    assign cur_en     = bus.ch_enable[idx_q];
    assign cur_vld    = bus.ch_valid[idx_q];

`ifdef APU_HOLD_LAST_EN
    logic [15:0] last_q [NUM_CH];

    // Remember each channel's most recent accepted sample for underrun fill-in
    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            for (int k = 0; k < NUM_CH; k++) last_q[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (ready_c[k]) last_q[k] <= bus.ch_sample[16*k +: 16];
            end
        end
    end

    assign fill_val = last_q[idx_q];
`else
    assign fill_val = '0;
`endif

    // A valid slot contributes its sample, an underrun slot the fill value
    assign slot_val = cur_vld ? cur_sample : fill_val;

    // Free-running frame position counter
    always_comb begin
        if (frame_pos_q == FP_W'(FRAME_LEN - 1)) frame_pos_d = '0;
        else                                      frame_pos_d = frame_pos_q + 1'b1;
    end

    // Scheduler FSM: next state, slot handshake, accumulation and scaling
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        pending_d = pending_q;
        ready_c   = '0;
        set_c     = '0;
        shifted   = acc_q >>> bus.atten;
        case (state_q)
            ST_WAIT: begin
                if (frame_pos_q == '0) begin
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = ST_GATHER;
                end
            end
            ST_GATHER: begin
                if (cur_en) begin
                    if (cur_vld) ready_c[idx_q] = 1'b1;
                    else         set_c[idx_q]   = 1'b1;
                    acc_d = acc_q + {{(ACC_W-16){slot_val[15]}}, slot_val};
                end
                if (idx_q == IDX_W'(NUM_CH - 1)) state_d = ST_SCALE;
                else                             idx_d   = idx_q + 1'b1;
            end
            ST_SCALE: begin
                if (shifted > SAT_MAX)      pending_d = 16'h7FFF;
                else if (shifted < SAT_MIN) pending_d = 16'h8000;
                else                        pending_d = shifted[15:0];
                state_d = ST_WAIT;
            end
            default: state_d = ST_WAIT;
        endcase
    end

    // Output and sticky-flag next values; a same-cycle set beats the clear
    always_comb begin
        sample_d   = (frame_pos_q == FP_W'(UPDATE_POS)) ? pending_q : sample_q;
        underrun_d = (underrun_q & ~{NUM_CH{bus.underrun_clr}}) | set_c;
    end

    // State registers; reset discards any partial frame
    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            state_q     <= ST_WAIT;
            frame_pos_q <= '0;
            idx_q       <= '0;
            acc_q       <= '0;
            pending_q   <= '0;
            sample_q    <= '0;
            underrun_q  <= '0;
        end else begin
            state_q     <= state_d;
            frame_pos_q <= frame_pos_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            pending_q   <= pending_d;
            sample_q    <= sample_d;
            underrun_q  <= underrun_d;
        end
    end

    // frame_start is gated by reset so every output reads 0 while held in reset
    assign bus.frame_start = reset_l && (frame_pos_q == '0);
    assign bus.ch_ready    = ready_c;
    assign bus.underrun    = underrun_q;
    assign bus.sample      = sample_q;
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_apu_mix_sched.sv
// tb_apu_mix_sched: frame-level reference model for apu_mix_sched.
// The driver picks one channel configuration per frame, predicts that frame's
// mixed sample and underrun flags from the mixing rules, and queues per-cycle
// expectations; the monitor pops one entry per cycle and compares.
module tb_apu_mix_sched;
    localparam int NUM_CH     = 4;
    localparam int FRAME_LEN  = 32;
    localparam int UPDATE_POS = 8;

    typedef struct {
        int                pos;
        logic [NUM_CH-1:0] rdy;
        logic [15:0]       smp;
        logic              fs;
        logic              chk_und;
        logic [NUM_CH-1:0] und;
    } exp_t;

    logic       clock;
    logic       reset_l;
    logic [1:0] dbg_state;

    apu_mix_sched_if #(.NUM_CH(NUM_CH)) bus ();

    apu_mix_sched #(
        .NUM_CH    (NUM_CH),
        .FRAME_LEN (FRAME_LEN),
        .UPDATE_POS(UPDATE_POS)
    ) dut (
        .clock      (clock),
        .reset_l    (reset_l),
        .bus        (bus.slave),
        .dbg_state_o(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    exp_t mon_q[$];
    int   checks   = 0;
    int   failures = 0;

    int                pos;
    int                frame_no;
    logic [NUM_CH-1:0] cfg_en;
    logic [NUM_CH-1:0] cfg_v;
    logic [15:0]       cfg_smp [NUM_CH];
    logic [2:0]        cfg_att;
    int                cfg_clr;
    logic [15:0]       mdl_last [NUM_CH];
    logic [NUM_CH-1:0] und_prev;
    logic [15:0]       frame_exp;
    logic [NUM_CH-1:0] frame_und;
    logic [15:0]       shown;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, req, $time);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic model_frame();
        int                sum;
        int                sh;
        logic [NUM_CH-1:0] set_m;
        sum   = 0;
        set_m = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (cfg_en[k]) begin
                if (cfg_v[k]) begin
                    sum += int'($signed(cfg_smp[k]));
                    mdl_last[k] = cfg_smp[k];
                end else begin
                    set_m[k] = 1'b1;
`ifdef APU_HOLD_LAST_EN
                    sum += int'($signed(mdl_last[k]));
`endif
                end
            end
        end
        sh = sum >>> cfg_att;
        if (sh > 32767)       sh = 32767;
        else if (sh < -32768) sh = -32768;
        frame_exp = 16'(sh);
        // Channel k raises its flag at frame position k+1; a clear at position
        // p wipes everything set before p, and loses to a set at p itself.
        if (cfg_clr < 0) begin
            frame_und = und_prev | set_m;
        end else begin
            frame_und = '0;
            for (int k = 0; k < NUM_CH; k++)
                if (set_m[k] && (k + 1 >= cfg_clr)) frame_und[k] = 1'b1;
        end
        und_prev = frame_und;
    endtask

    // ---------------- driver tasks ----------------
    task automatic pick_frame(input int f);
        int pick;
        cfg_clr = -1;
        cfg_att = 3'd0;
        for (int k = 0; k < NUM_CH; k++) cfg_smp[k] = 16'($urandom);
        case (f)
            0: begin cfg_en = 4'b1111; cfg_v = 4'b0000; end
            1: begin
                cfg_en = 4'b1111; cfg_v = 4'b1111; cfg_clr = 0;
                cfg_smp[0] = 16'd100; cfg_smp[1] = 16'd200;
                cfg_smp[2] = -16'sd50; cfg_smp[3] = 16'd1000;
            end
            2, 3, 4, 5: begin
                cfg_en = 4'b1111; cfg_v = 4'b1111;
                cfg_att = (f >= 4) ? 3'd2 : 3'd0;
                for (int k = 0; k < NUM_CH; k++)
                    cfg_smp[k] = (f == 2 || f == 4) ? 16'h7FFF : 16'h8000;
            end
            6, 7: begin
                cfg_en = 4'b0101; cfg_v = 4'b1011; cfg_smp[0] = 16'd300;
                cfg_clr = (f == 7) ? 3 : -1;
            end
            8: begin cfg_en = 4'b0001; cfg_v = 4'b0001; cfg_smp[0] = 16'd500; cfg_clr = 0; end
            9: begin cfg_en = 4'b0001; cfg_v = 4'b0000; end
            default: begin
                cfg_en  = 4'($urandom_range(0, 15));
                for (int k = 0; k < NUM_CH; k++) cfg_v[k] = ($urandom_range(0, 3) != 0);
                cfg_att = 3'($urandom_range(0, 7));
                pick = $urandom_range(0, 5);
                case (pick)
                    2:       cfg_clr = 0;
                    3:       cfg_clr = 2;
                    4:       cfg_clr = 3;
                    5:       cfg_clr = 20;
                    default: cfg_clr = -1;
                endcase
            end
        endcase
        bus.ch_enable = cfg_en;
        bus.ch_valid  = cfg_v;
        bus.atten     = cfg_att;
        for (int k = 0; k < NUM_CH; k++) bus.ch_sample[16*k +: 16] = cfg_smp[k];
        model_frame();
    endtask

    // Called just after each rising edge with pos = the DUT's frame position
    task automatic run_cycle();
        exp_t e;
        if (pos == 0) begin
            pick_frame(frame_no);
            frame_no++;
        end
        bus.underrun_clr = (cfg_clr == pos);
        if (pos == UPDATE_POS + 1) shown = frame_exp;
        e.pos = pos;
        e.rdy = '0;
        if (pos >= 1 && pos <= NUM_CH)
            if (cfg_en[pos-1] && cfg_v[pos-1]) e.rdy[pos-1] = 1'b1;
        e.smp     = shown;
        e.fs      = (pos == 0);
        e.chk_und = (pos == FRAME_LEN - 1);
        e.und     = frame_und;
        mon_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        pos = (pos + 1) % FRAME_LEN;
        run_cycle();
    endtask

    task automatic release_reset();
        reset_l  = 1'b1;
        pos      = 0;
        shown    = '0;
        und_prev = '0;
        for (int k = 0; k < NUM_CH; k++) mdl_last[k] = '0;
        run_cycle();
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (mon_q.size() > 0) begin
                e = mon_q.pop_front();
                check($sformatf("ch_ready@pos%0d", e.pos), 32'(bus.ch_ready), 32'(e.rdy));
                check($sformatf("sample@pos%0d", e.pos), 32'(bus.sample), 32'(e.smp));
                check($sformatf("frame_start@pos%0d", e.pos), 32'(bus.frame_start), 32'(e.fs));
                if (e.chk_und)
                    check("underrun@frame_end", 32'(bus.underrun), 32'(e.und));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset_l          = 1'b0;
        frame_no         = 0;
        cfg_clr          = -1;
        bus.ch_sample    = '0;
        bus.ch_valid     = '0;
        bus.ch_enable    = '0;
        bus.atten        = '0;
        bus.underrun_clr = 1'b0;
        #2;
        check("reset sample", 32'(bus.sample), 32'h0);
        check("reset ch_ready", 32'(bus.ch_ready), 32'h0);
        check("reset underrun", 32'(bus.underrun), 32'h0);
        check("reset frame_start", 32'(bus.frame_start), 32'h0);
        repeat (3) @(posedge clock);
        #1;
        release_reset();
        repeat (36 * FRAME_LEN - 1) step();

        // Reset in the middle of GATHER (frame position 3)
        while (pos != 2) step();
        @(posedge clock);
        #1;
        bus.ch_valid     = '1;
        bus.ch_enable    = '1;
        bus.underrun_clr = 1'b0;
        reset_l          = 1'b0;
        #1;
        check("midreset sample", 32'(bus.sample), 32'h0);
        check("midreset ch_ready", 32'(bus.ch_ready), 32'h0);
        check("midreset underrun", 32'(bus.underrun), 32'h0);
        check("midreset frame_start", 32'(bus.frame_start), 32'h0);
        repeat (2) @(posedge clock);
        #1;
        release_reset();
        repeat (6 * FRAME_LEN) step();

        repeat (2) @(negedge clock);
        check("scoreboard drained", 32'(mon_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
